// File: rtl/bextdep_pkg.sv
// Shared types and constants for the iterative bext/bdep unit.
// Holds the FSM state enum, default operand width and opcode values.
package bextdep_pkg;

   localparam int XLEN = 32;

   localparam logic OP_BEXT = 1'b0;
   localparam logic OP_BDEP = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bextdep_chunk.sv
// Combinational step of bext/bdep: folds one STEP-bit mask slice into acc.
// In: op, mask, rs1_q, acc, j, k. Out: acc_nxt, j_nxt.
module bextdep_chunk
   import bextdep_pkg::*;
#(
   parameter int XLEN = bextdep_pkg::XLEN,
   parameter int STEP = 4,
   parameter int LW   = $clog2(XLEN),
   parameter int JW   = LW + 1,
   parameter int KW   = $clog2(XLEN / STEP)
) (
   input  logic            op,
   input  logic [STEP-1:0] mask,
   input  logic [XLEN-1:0] rs1_q,
   input  logic [XLEN-1:0] acc,
   input  logic [JW-1:0]   j,
   input  logic [KW-1:0]   k,
   output logic [XLEN-1:0] acc_nxt,
   output logic [JW-1:0]   j_nxt
);

   logic [JW-1:0] jj;
   logic [LW-1:0] pos;

   // jj never exceeds the mask bit position, so jj[LW-1:0] is always
   // in range whenever a set mask bit uses it.
   always_comb begin
      acc_nxt = acc;
      jj      = j;
      pos     = '0;
      for (int s = 0; s < STEP; s++) begin
         pos = LW'(int'(k) * STEP + s);
         if (mask[s]) begin
            if (op == OP_BDEP)
               acc_nxt[pos] = rs1_q[jj[LW-1:0]];
            else
               acc_nxt[jj[LW-1:0]] = rs1_q[pos];
            jj = jj + JW'(1);
         end
      end
      j_nxt = jj;
   end

endmodule

// File: rtl/bextdep_iter.sv
// Iterative bext/bdep unit, STEP mask bits per cycle, valid/ready on both sides.
// Ports: clock, resetn, in_valid/in_ready, bdep, rs1, rs2, out_valid/out_ready, rd.
module bextdep_iter
   import bextdep_pkg::*;
#(
   parameter int XLEN = bextdep_pkg::XLEN,
   parameter int STEP = 4
) (
   input  logic            clock,
   input  logic            resetn,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            bdep,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] rd
);

   localparam int LW = $clog2(XLEN);
   localparam int JW = LW + 1;
   localparam int NK = XLEN / STEP;
   localparam int KW = $clog2(NK);

   state_t          state;
   logic            op;
   logic [XLEN-1:0] rs1_q;
   logic [XLEN-1:0] rs2_q;
   logic [XLEN-1:0] acc;
   logic [JW-1:0]   j;
   logic [KW-1:0]   k;

   logic [STEP-1:0] mask;
   logic [XLEN-1:0] acc_nxt;
   logic [JW-1:0]   j_nxt;

   assign mask = rs2_q[int'(k) * STEP +: STEP];

   bextdep_chunk #(
      .XLEN (XLEN),
      .STEP (STEP),
      .LW   (LW),
      .JW   (JW),
      .KW   (KW)
   ) u_chunk (
      .op      (op),
      .mask    (mask),
      .rs1_q   (rs1_q),
      .acc     (acc),
      .j       (j),
      .k       (k),
      .acc_nxt (acc_nxt),
      .j_nxt   (j_nxt)
   );

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state     <= IDLE;
         op        <= OP_BEXT;
         rs1_q     <= '0;
         rs2_q     <= '0;
         acc       <= '0;
         j         <= '0;
         k         <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         rd        <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  op       <= bdep;
                  rs1_q    <= rs1;
                  rs2_q    <= rs2;
                  acc      <= '0;
                  j        <= '0;
                  k        <= '0;
                  in_ready <= 1'b0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               acc <= acc_nxt;
               j   <= j_nxt;
               k   <= k + KW'(1);
               if (k == KW'(NK - 1)) begin
                  rd        <= acc_nxt;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               // in_ready rises only on the next edge, so no request
               // can slip in while the result is being handed off.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bextdep_iter.sv
// Self-checking bench for bextdep_iter against a queue-based bit model.
// Directed cases, stall, reset abort, issue interval and random streams.
module tb_bextdep_iter;

   logic        clock;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic        bdep;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] rd;

   int nchk;
   int nfail;
   int ncomp;
   int nacc;
   int cyc;
   logic [31:0] exp_q[$];
   int acc_cyc[$];

   bextdep_iter dut (
      .clock     (clock),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bdep      (bdep),
      .rs1       (rs1),
      .rs2       (rs2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .rd        (rd)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [31:0] ref_bext(logic [31:0] a, logic [31:0] m);
      logic        bits[$];
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++)
         if (m[i]) bits.push_back(a[i]);
      foreach (bits[n]) r[n] = bits[n];
      return r;
   endfunction

   function automatic logic [31:0] ref_bdep(logic [31:0] a, logic [31:0] m);
      logic        bits[$];
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) bits.push_back(a[i]);
      for (int i = 0; i < 32; i++)
         if (m[i]) r[i] = bits.pop_front();
      return r;
   endfunction

   function automatic logic [31:0] ref_op(logic op, logic [31:0] a,
                                          logic [31:0] m);
      return op ? ref_bdep(a, m) : ref_bext(a, m);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Handshakes sampled mid-cycle: they describe the upcoming posedge.
   always @(negedge clock) begin
      cyc++;
      if (!resetn) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            ncomp++;
            if (exp_q.size() == 0)
               check("unexpected_result", rd, 32'hx);
            else
               check("stream_rd", rd, exp_q.pop_front());
         end
         if (in_valid && in_ready) begin
            nacc++;
            acc_cyc.push_back(cyc);
            exp_q.push_back(ref_op(bdep, rs1, rs2));
         end
      end
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic wait_ready;
      int g;
      g = 0;
      while (!in_ready && g < 100) begin
         tick();
         g++;
      end
      if (g >= 100) check("wait_in_ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_op(input string tag, input logic op,
                        input logic [31:0] a, input logic [31:0] m,
                        input logic [31:0] exp);
      int   lat;
      logic busy_ok;
      wait_ready();
      bdep = op; rs1 = a; rs2 = m; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      bdep = ~op; rs1 = $urandom; rs2 = $urandom;
      lat = 0;
      busy_ok = 1'b1;
      while (!out_valid && lat < 40) begin
         if (in_ready) busy_ok = 1'b0;
         tick();
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'd8);
      check({tag, "_busy_ready"}, {31'd0, busy_ok}, 32'd1);
      check({tag, "_rd"}, rd, exp);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
      check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      logic [31:0] hold_rd;
      logic        stable;
      int          c0;
      int          a0;
      int          g;
      int          target;

      nchk = 0; nfail = 0; ncomp = 0; nacc = 0; cyc = 0;
      resetn = 1'b0; in_valid = 1'b0; bdep = 1'b0;
      rs1 = '0; rs2 = '0; out_ready = 1'b0;
      tick(); tick();
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      check("reset_rd", rd, 32'd0);
      resetn = 1'b1;
      tick();

      do_op("bext_a", 1'b0, 32'h12345678, 32'h0000FF00, 32'h00000056);
      do_op("bdep_a", 1'b1, 32'h000000AB, 32'h00FF0000, 32'h00AB0000);
      do_op("bext_b", 1'b0, 32'hFFFFFFFF, 32'h55555555, 32'h0000FFFF);
      do_op("bdep_b", 1'b1, 32'h0000FFFF, 32'hAAAAAAAA, 32'hAAAAAAAA);
      do_op("bext_m0", 1'b0, 32'hDEADBEEF, 32'h00000000, 32'h00000000);
      do_op("bdep_m0", 1'b1, 32'hDEADBEEF, 32'h00000000, 32'h00000000);
      do_op("bext_m1", 1'b0, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF);
      do_op("bdep_m1", 1'b1, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF);

      // Stall with out_ready low while a new request is pending.
      wait_ready();
      bdep = 1'b0; rs1 = 32'hCAFEF00D; rs2 = 32'hF0F0F0F0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      g = 0;
      while (!out_valid && g < 40) begin
         tick();
         g++;
      end
      check("stall_reach_done", {31'd0, out_valid}, 32'd1);
      hold_rd = rd;
      check("stall_rd", hold_rd, ref_bext(32'hCAFEF00D, 32'hF0F0F0F0));
      a0 = nacc;
      stable = 1'b1;
      in_valid = 1'b1; bdep = 1'b1; rs1 = $urandom; rs2 = $urandom;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (!out_valid || rd !== hold_rd || in_ready) stable = 1'b0;
      end
      check("stall_stable", {31'd0, stable}, 32'd1);
      check("stall_no_accept", 32'(nacc), 32'(a0));
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("stall_release_ready", {31'd0, in_ready}, 32'd1);
      check("stall_release_valid", {31'd0, out_valid}, 32'd0);

      // Reset in the third BUSY cycle discards the operation.
      bdep = 1'b0; rs1 = 32'h87654321; rs2 = 32'hFFFF0000; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      check("abort_valid", {31'd0, out_valid}, 32'd0);
      check("abort_ready", {31'd0, in_ready}, 32'd1);
      check("abort_rd", rd, 32'd0);
      c0 = ncomp;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      out_ready = 1'b0;
      check("abort_no_stale", 32'(ncomp), 32'(c0));
      do_op("after_abort", 1'b1, 32'h0000003C, 32'h0F000F00, 32'h03000C00);

      // Back-to-back issue with out_ready tied high.
      acc_cyc.delete();
      c0 = ncomp;
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int n = 0; n < 5; n++) begin
         bdep = 1'($urandom); rs1 = $urandom; rs2 = $urandom;
         wait_ready();
         tick();
      end
      in_valid = 1'b0;
      g = 0;
      while (ncomp < c0 + 5 && g < 100) begin
         tick();
         g++;
      end
      check("interval_count", 32'(acc_cyc.size()), 32'd5);
      for (int n = 0; n + 1 < acc_cyc.size(); n++)
         check("issue_interval", 32'(acc_cyc[n+1] - acc_cyc[n]), 32'd10);
      out_ready = 1'b0;

      // Random streams: bext phase then bdep phase, random gaps.
      for (int ph = 0; ph < 2; ph++) begin
         target = ncomp + 1000;
         fork
            begin
               for (int n = 0; n < 1000; n++) begin
                  in_valid = 1'b0;
                  repeat ($urandom_range(0, 3)) tick();
                  bdep = 1'(ph); rs1 = $urandom;
                  case ($urandom_range(0, 3))
                     0: rs2 = 32'h0;
                     1: rs2 = 32'hFFFFFFFF;
                     default: rs2 = $urandom;
                  endcase
                  in_valid = 1'b1;
                  wait_ready();
                  tick();
               end
               in_valid = 1'b0;
            end
            begin
               g = 0;
               while (ncomp < target && g < 40000) begin
                  out_ready = 1'($urandom_range(0, 1));
                  tick();
                  g++;
               end
               out_ready = 1'b0;
            end
         join
         check("stream_complete", 32'(ncomp), 32'(target));
      end
      check("stream_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule

// File: doc/bextdep_iter.md
# bextdep_iter

Iterative, area-optimised bit-extract (bext) / bit-deposit (bdep) unit. It computes the same results as the single-issue pipelined bext/bdep datapath, but trades throughput for area by walking the mask STEP bits per cycle. The unit sits behind a valid/ready request channel and a valid/ready response channel, so a core or test driver can issue operations and drain results at its own pace. It reuses the same 96-bit-per-vector bext/bdep test data.

## Interface
- XLEN, 32: operand/result width.
- STEP, 4: mask bits processed per cycle; one of 1, 2, 4, 8; XLEN % STEP == 0.
- clock  in  1  sole clock; all state updates on posedge.
- resetn  in  1  synchronous, active-low reset, sampled on posedge clock.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- bdep  in  1  0 = bext, 1 = bdep; sampled with the request.
- rs1  in  XLEN  data operand.
- rs2  in  XLEN  mask operand.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- rd  out  XLEN  result.

## Operation
- bext: for i ascending, if rs2[i] then rd[j] = rs1[i], j++. Remaining upper rd bits are 0.
- bdep: for i ascending, if rs2[i] then rd[i] = rs1[j], j++. Other rd bits are 0.
- Datapath registers: op, rs1_q, rs2_q, acc (XLEN), j (clog2(XLEN)+1 bits), chunk counter k (clog2(XLEN/STEP) bits).
- FSM states:
  - IDLE: in_ready = 1. When in_valid is high, capture bdep/rs1/rs2, clear acc/j/k, and go to BUSY.
  - BUSY: each cycle process mask bits [k·STEP +: STEP] and update acc.
    - j advances by the popcount of the chunk.
    - On k == XLEN/STEP−1, go to DONE with rd = final acc.
  - DONE: out_valid = 1. When out_ready is high, go to IDLE.
- in_ready is 0 in BUSY and DONE. Requests are never accepted in DONE, even if out_ready is high in the same cycle.
- Operands are captured at acceptance. Changes on rs1/rs2/bdep after acceptance are ignored.
- rd and out_valid stay stable while out_valid = 1 and out_ready = 0. Stalls have no limit.
- j never exceeds XLEN. Index arithmetic on rs1_q/acc uses j modulo XLEN only within valid range; no out-of-range bit selects.
- Boundary cases:
  - rs2 = 0 gives rd = 0.
  - rs2 = all-ones gives rd = rs1 for both ops.

## Timing
- Reset (resetn = 0 at a posedge):
  - state = IDLE, out_valid = 0, in_ready = 1 from that edge onward, rd = 0, internal registers = 0.
- Reset mid-operation (BUSY or DONE) aborts the operation. No result is emitted, and the pending result is discarded.
- Latency: request accepted at edge t gives out_valid = 1 after edge t + XLEN/STEP. With defaults, that is 8 cycles.
- Minimum issue interval with out_ready tied high: XLEN/STEP + 2 cycles (10 with defaults).
- Outputs are registered. There is no combinational path from in_valid/out_ready to in_ready/out_valid.

## Structure
- Package bextdep_pkg:
  - state enum {IDLE, BUSY, DONE};
  - default XLEN;
  - an opcode constant (OP_BEXT = 0, OP_BDEP = 1).
- Sub-module bextdep_chunk (combinational):
  - inputs: op, STEP-bit mask slice, rs1_q, acc, j, k;
  - outputs: next acc and next j.
  - The top contains only the FSM, counters and registers.

## Test plan
- bext rs1=0x12345678, rs2=0x0000FF00 → rd=0x00000056, out_valid exactly 8 cycles after acceptance, in_ready=0 throughout.
- bdep rs1=0x000000AB, rs2=0x00FF0000 → rd=0x00AB0000. Then bext rs1=0xFFFFFFFF, rs2=0x55555555 → 0x0000FFFF. Then bdep rs1=0x0000FFFF, rs2=0xAAAAAAAA → 0xAAAAAAAA.
- rs2=0 → rd=0 for both ops. rs2=0xFFFFFFFF, rs1=0xDEADBEEF → rd=0xDEADBEEF for both ops.
- Hold out_ready=0 for 20 cycles after out_valid:
  - rd and out_valid stay stable;
  - in_ready stays 0, and an asserted in_valid is not accepted;
  - releasing out_ready returns the unit to IDLE after one edge.
- Drive resetn=0 at cycle 3 of BUSY, then issue a new request:
  - out_valid stays 0 with no stale result;
  - the new request completes correctly.
- Stream all 1000 bext then 1000 bdep vectors from testdata_bext.hex/testdata_bdep.hex with random in_valid/out_ready gaps:
  - every rd matches;
  - in-order completion;
  - issue interval with out_ready tied high is exactly 10 cycles.
